// File: rtl/cr_tlvp_ob_arb.sv
// Frame-atomic round-robin arbiter: merges N_REQ FIFO-style TLV beat streams onto one
// downstream FIFO read interface, switching owner only after an end-of-frame beat.
module cr_tlvp_ob_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 80,
    parameter int MAX_BEATS = 1024,
    parameter int CNT_W     = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_empty,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_rd,
    input  logic                      ob_rd,
    output logic                      ob_empty,
    output logic [DATA_W-1:0]         ob_data,
    output logic                      ob_last,
    output logic                      grant_vld,
    output logic [2:0]                grant_id,
    output logic                      frame_err
);

    // state  | meaning
    // S_IDLE | no owner; pick next non-empty requester after last_grant
    // S_BUSY | grant_id owns the output until its last beat is popped
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [2:0]         last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               frame_err_q, frame_err_d;

    logic               sel_found;
    logic [2:0]         sel_id;
    logic               accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= 3'(N_REQ - 1);
            beat_cnt_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Rotating priority: the first non-empty requester after last_grant wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!sel_found && !req_empty[i] &&
                    ((int'(last_grant_q) + k) % N_REQ) == i) begin
                    sel_found = 1'b1;
                    sel_id    = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        frame_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d    = S_BUSY;
                    grant_id_d = sel_id;
                    beat_cnt_d = '0;
                end
            end
            S_BUSY: begin
                if (accept) begin
                    if (beat_cnt_q != '1)
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    // Count can only pass through MAX_BEATS-1 once per frame, so this fires once.
                    if (!ob_last && beat_cnt_q == CNT_W'(MAX_BEATS - 1))
                        frame_err_d = 1'b1;
                    if (ob_last) begin
                        state_d      = S_IDLE;
                        last_grant_d = grant_id_q;
                        beat_cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ob_empty = 1'b1;
        ob_data  = '0;
        ob_last  = 1'b0;
        req_rd   = '0;
        if (state_q == S_BUSY) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_id_q == 3'(i)) begin
                    ob_empty = req_empty[i];
                    if (!req_empty[i]) begin
                        ob_data   = req_data[i*DATA_W +: DATA_W];
                        ob_last   = req_last[i];
                        req_rd[i] = ob_rd;
                    end
                end
            end
        end
    end

    assign accept    = |req_rd;
    assign grant_vld = (state_q == S_BUSY);
    assign grant_id  = grant_id_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cr_tlvp_ob_arb.sv
// Directed bench for cr_tlvp_ob_arb: requesters are simple FIFO fronts whose head beat
// encodes {requester, beat index}; expected values are hand-computed per scenario.
module tb_cr_tlvp_ob_arb;
    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_empty;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_rd;
    logic            ob_rd;
    logic            ob_empty;
    logic [DW-1:0]   ob_data;
    logic            ob_last;
    logic            grant_vld;
    logic [2:0]      grant_id;
    logic            frame_err;

    int              pos [N];
    int              flen [N];
    logic [N-1:0]    en;
    int              n_tests = 0;
    int              n_fail  = 0;

    cr_tlvp_ob_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_empty(req_empty), .req_data(req_data),
        .req_last(req_last), .req_rd(req_rd), .ob_rd(ob_rd), .ob_empty(ob_empty),
        .ob_data(ob_data), .ob_last(ob_last), .grant_vld(grant_vld),
        .grant_id(grant_id), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] dexp(input int r, input int p);
        return {16'h0, 8'(r), 8'(p)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_empty[i]          = ~en[i];
            req_data[i*DW +: DW]  = {8'(i), 8'(pos[i])};
            req_last[i]           = ((pos[i] % flen[i]) == flen[i] - 1);
        end
    endtask

    // Pops are sampled mid-cycle, applied just after the edge, then inputs re-driven.
    task automatic tick();
        logic [N-1:0] rd;
        @(negedge clk);
        rd = req_rd;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (rd[i]) pos[i]++;
        drive();
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] en_v, input int fl);
        rst_n = 1'b0;
        ob_rd = 1'b0;
        en    = en_v;
        for (int i = 0; i < N; i++) begin
            pos[i]  = 0;
            flen[i] = fl;
        end
        drive();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // ---- reset values, then a 3-beat frame from req0 ----
        en = '1; ob_rd = 1'b0;
        for (int i = 0; i < N; i++) begin pos[i] = 0; flen[i] = 3; end
        drive();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ob_empty", 32'(ob_empty), 32'd1);
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_req_rd", 32'(req_rd), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_ob_data", 32'(ob_data), 32'd0);
        chk("rst_ob_last", 32'(ob_last), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        chk("t1_grant_vld", 32'(grant_vld), 32'd1);
        chk("t1_grant_id", 32'(grant_id), 32'd0);
        chk("t1_ob_empty", 32'(ob_empty), 32'd0);
        chk("t1_ob_data", 32'(ob_data), dexp(0, 0));
        ob_rd = 1'b1;
        #1;
        for (int b = 0; b < 3; b++) begin
            chk("t1_req_rd", 32'(req_rd), 32'h1);
            chk("t1_ob_last", 32'(ob_last), (b == 2) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t1_idle_vld", 32'(grant_vld), 32'd0);
        chk("t1_idle_empty", 32'(ob_empty), 32'd1);
        chk("t1_idle_rd", 32'(req_rd), 32'd0);
        chk("t1_idle_gid_hold", 32'(grant_id), 32'd0);
        tick();
        chk("t1_next_gid", 32'(grant_id), 32'd1);
        chk("t1_next_data", 32'(ob_data), dexp(1, 0));

        // ---- continuous 2-beat frames from all four: rotation 0,1,2,3,0 ----
        do_reset('1, 2);
        ob_rd = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            int g;
            tick();
            g = (k / 3) % 4;
            if (k % 3 == 1) begin
                chk("rr_gid", 32'(grant_id), 32'(g));
                chk("rr_vld", 32'(grant_vld), 32'd1);
                chk("rr_rd", 32'(req_rd), 32'(1 << g));
                chk("rr_data", 32'(ob_data), dexp(g, 2 * ((k - 1) / 12)));
            end else if (k % 3 == 2) begin
                chk("rr_last", 32'(ob_last), 32'd1);
            end else begin
                chk("rr_gap_vld", 32'(grant_vld), 32'd0);
                chk("rr_gap_empty", 32'(ob_empty), 32'd1);
            end
        end

        // ---- bubble in granted req2 while req3 waits ----
        do_reset(4'b1100, 3);
        flen[3] = 2;
        drive();
        ob_rd = 1'b1;
        tick();
        chk("bub_gid", 32'(grant_id), 32'd2);
        tick();
        en[2] = 1'b0;
        drive();
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bub_hold_gid", 32'(grant_id), 32'd2);
            chk("bub_hold_empty", 32'(ob_empty), 32'd1);
            chk("bub_hold_rd", 32'(req_rd), 32'd0);
            tick();
        end
        en[2] = 1'b1;
        drive();
        #1;
        chk("bub_refill_data", 32'(ob_data), dexp(2, 1));
        tick();
        chk("bub_last", 32'(ob_last), 32'd1);
        tick();
        chk("bub_idle", 32'(grant_vld), 32'd0);
        tick();
        chk("bub_next_gid", 32'(grant_id), 32'd3);

        // ---- ob_rd toggling, ob_rd in IDLE, lone requester re-grant ----
        do_reset(4'b0010, 4);
        tick();
        chk("tog_gid", 32'(grant_id), 32'd1);
        for (int c = 0; c < 4; c++) begin
            ob_rd = (c % 2 == 0);
            #1;
            chk("tog_rd", 32'(req_rd), (c % 2 == 0) ? 32'h2 : 32'h0);
            tick();
        end
        chk("tog_data", 32'(ob_data), dexp(1, 2));
        ob_rd = 1'b1;
        tick();
        chk("tog_last", 32'(ob_last), 32'd1);
        tick();
        chk("tog_idle_rd", 32'(req_rd), 32'd0);
        chk("tog_idle_empty", 32'(ob_empty), 32'd1);
        tick();
        chk("tog_regrant", 32'(grant_id), 32'd1);
        chk("tog_no_loss", 32'(ob_data), dexp(1, 4));

        // ---- exactly MAX_BEATS beats: no frame_err ----
        do_reset(4'b0001, 4);
        ob_rd = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("fe4_err", 32'(frame_err), 32'd0);
        end

        // ---- 6-beat frame: one pulse after beat 4 ----
        do_reset(4'b0001, 6);
        ob_rd = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("fe6_err", 32'(frame_err), (k == 5) ? 32'd1 : 32'd0);
        end

        // ---- reset mid-frame at beat 2 of req1 ----
        do_reset(4'b0010, 4);
        ob_rd = 1'b1;
        tick();
        tick();
        chk("mid_pre_data", 32'(ob_data), dexp(1, 1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(ob_empty), 32'd1);
        chk("mid_rst_vld", 32'(grant_vld), 32'd0);
        chk("mid_rst_rd", 32'(req_rd), 32'd0);
        chk("mid_rst_gid", 32'(grant_id), 32'd0);
        en = 4'b1010;
        drive();
        tick();
        rst_n = 1'b1;
        #1;
        tick();
        chk("mid_regrant_gid", 32'(grant_id), 32'd1);
        chk("mid_regrant_data", 32'(ob_data), dexp(1, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
